// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Shared defaults for the raster timing generator. Holds the
//            640x480@60 horizontal/vertical timing, sync polarities, the
//            derived line/frame totals and the coordinate widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Sum of the four regions of one axis (visible, front, sync, back).
    function automatic int axis_total(input int visible, input int front,
                                      input int sync_w, input int back);
        return visible + front + sync_w + back;
    endfunction

    // Horizontal timing, in pixels
    localparam int   VGA_H_VISIBLE  = 640;
    localparam int   VGA_H_FRONT    = 16;
    localparam int   VGA_H_SYNC     = 96;
    localparam int   VGA_H_BACK     = 48;
    localparam logic VGA_H_SYNC_POL = 1'b0;

    // Vertical timing, in lines
    localparam int   VGA_V_VISIBLE  = 480;
    localparam int   VGA_V_FRONT    = 10;
    localparam int   VGA_V_SYNC     = 2;
    localparam int   VGA_V_BACK     = 33;
    localparam logic VGA_V_SYNC_POL = 1'b0;

    // Derived totals (800 x 525 for the defaults)
    localparam int VGA_H_TOTAL = axis_total(VGA_H_VISIBLE, VGA_H_FRONT,
                                            VGA_H_SYNC, VGA_H_BACK);
    localparam int VGA_V_TOTAL = axis_total(VGA_V_VISIBLE, VGA_V_FRONT,
                                            VGA_V_SYNC, VGA_V_BACK);

    // Coordinate widths; must hold TOTAL-1 of their axis
    localparam int VGA_X_WIDTH = 10;
    localparam int VGA_Y_WIDTH = 10;

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/sync_axis_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_axis_counter
// Purpose  : One raster axis. A wrapping counter 0..TOTAL-1 that advances on
//            each cycle with en=1, plus registered region flags derived from
//            the value being loaded so they line up with the count.
// Ports    : clk    - system clock
//            rst    - synchronous reset, active-low
//            en     - advance enable
//            count  - current position, 0..TOTAL-1
//            active - position is inside the visible region
//            sync   - sync level (POL inside the sync region, ~POL outside)
//            wrap   - count is at TOTAL-1 (next advance returns to 0)
// Revision : 1.0 - initial release
// ============================================================================
module sync_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   VISIBLE = VGA_H_VISIBLE,
    parameter int   FRONT   = VGA_H_FRONT,
    parameter int   SYNC    = VGA_H_SYNC,
    parameter int   BACK    = VGA_H_BACK,
    parameter logic POL     = VGA_H_SYNC_POL,
    parameter int   WIDTH   = VGA_X_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             active,
    output logic             sync,
    output logic             wrap
);

    localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

    localparam logic [WIDTH-1:0] c_last       = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] c_one        = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_visible    = WIDTH'(VISIBLE);
    localparam logic [WIDTH-1:0] c_sync_start = WIDTH'(VISIBLE + FRONT);
    localparam logic [WIDTH-1:0] c_sync_end   = WIDTH'(VISIBLE + FRONT + SYNC);

    logic [WIDTH-1:0] r_count;
    logic             r_active;
    logic             r_sync;
    logic             w_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_in_sync;

    // wrap depends only on the registered count, so the enable path into the
    // next axis never reaches an output combinationally.
    always_comb begin
        w_wrap    = (r_count == c_last);
        w_next    = w_wrap ? '0 : (r_count + c_one);
        w_in_sync = (w_next >= c_sync_start) && (w_next < c_sync_end);
    end

    // Region flags are computed from w_next so they change on the same edge
    // as the count they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count  <= c_last;
            r_active <= 1'b0;
            r_sync   <= ~POL;
        end else if (en) begin
            r_count  <= w_next;
            r_active <= (w_next < c_visible);
            r_sync   <= w_in_sync ? POL : ~POL;
        end
    end

    assign count  = r_count;
    assign active = r_active;
    assign sync   = r_sync;
    assign wrap   = w_wrap;

endmodule : sync_axis_counter
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Raster timing generator in the clk domain. tick is a pixel
//            clock enable; each tick advances (x,y) through the frame and
//            updates syncs, display enable and start-of-line/frame pulses.
// Ports    : clk         - system clock
//            rst         - synchronous reset, active-low
//            tick        - pixel-rate enable
//            hsync       - horizontal sync (H_SYNC_POL when active)
//            vsync       - vertical sync (V_SYNC_POL when active)
//            display_on  - (x,y) is inside the visible area
//            x, y        - raster coordinates
//            line_start  - one-clk pulse when x becomes 0
//            frame_start - one-clk pulse when (x,y) becomes (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE  = VGA_H_VISIBLE,
    parameter int   H_FRONT    = VGA_H_FRONT,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BACK     = VGA_H_BACK,
    parameter int   V_VISIBLE  = VGA_V_VISIBLE,
    parameter int   V_FRONT    = VGA_V_FRONT,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BACK     = VGA_V_BACK,
    parameter logic H_SYNC_POL = VGA_H_SYNC_POL,
    parameter logic V_SYNC_POL = VGA_V_SYNC_POL,
    parameter int   X_WIDTH    = VGA_X_WIDTH,
    parameter int   Y_WIDTH    = VGA_Y_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               line_start,
    output logic               frame_start
);

    logic w_h_active;
    logic w_h_wrap;
    logic w_v_active;
    logic w_v_wrap;
    logic w_v_en;
    logic r_line_start;
    logic r_frame_start;

    // The vertical axis steps only on the tick that wraps the line.
    assign w_v_en = tick & w_h_wrap;

    sync_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (H_SYNC_POL),
        .WIDTH   (X_WIDTH)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (tick),
        .count  (x),
        .active (w_h_active),
        .sync   (hsync),
        .wrap   (w_h_wrap)
    );

    sync_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (V_SYNC_POL),
        .WIDTH   (Y_WIDTH)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .en     (w_v_en),
        .count  (y),
        .active (w_v_active),
        .sync   (vsync),
        .wrap   (w_v_wrap)
    );

    // Pulses are reloaded every clk, so they last one cycle even with tick
    // held high; the wrap conditions hold for only one tick per line/frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= tick & w_h_wrap;
            r_frame_start <= tick & w_h_wrap & w_v_wrap;
        end
    end

    // AND of two registered flags: same edge, same latency as x/y.
    assign display_on  = w_h_active & w_v_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule : vga_timing
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Purpose  : Directed self-checking bench for vga_timing. Three instances:
//            640x480 defaults, a short-line/default-frame instance for full
//            vertical timing, and a fully reduced instance with POL=1.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 640x480 defaults
    logic       d_rst, d_tick, d_hsync, d_vsync, d_disp, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    // 7-pixel lines, default 525-line frame
    logic       m_rst, m_tick, m_hsync, m_vsync, m_disp, m_ls, m_fs;
    logic [2:0] m_x;
    logic [9:0] m_y;
    // H=4/1/1/1, V=2/1/1/1, both polarities high
    logic       r_rst, r_tick, r_hsync, r_vsync, r_disp, r_ls, r_fs;
    logic [2:0] r_x, r_y;

    vga_timing u_dut_d (
        .clk(clk), .rst(d_rst), .tick(d_tick), .hsync(d_hsync), .vsync(d_vsync),
        .display_on(d_disp), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1), .X_WIDTH(3)
    ) u_dut_m (
        .clk(clk), .rst(m_rst), .tick(m_tick), .hsync(m_hsync), .vsync(m_vsync),
        .display_on(m_disp), .x(m_x), .y(m_y), .line_start(m_ls), .frame_start(m_fs)
    );

    vga_timing #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .X_WIDTH(3), .Y_WIDTH(3)
    ) u_dut_r (
        .clk(clk), .rst(r_rst), .tick(r_tick), .hsync(r_hsync), .vsync(r_vsync),
        .display_on(r_disp), .x(r_x), .y(r_y), .line_start(r_ls), .frame_start(r_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clk edge, then settle so outputs are sampled off the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int xv, yv, mx, my, rx, ry;
        int hs_low, hs_bad, disp_cnt, disp_bad, ls_cnt, fs_cnt, idle_pulse, pos_bad;
        int vs_low, vs_bad, ls_bad, fs_bad, fs_first, fs_last;
        bit found, els, efs;

        d_rst = 1'b0; d_tick = 1'b0;
        m_rst = 1'b0; m_tick = 1'b0;
        r_rst = 1'b0; r_tick = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) cyc();
        check("rst_x", 32'(d_x), 799);
        check("rst_y", 32'(d_y), 524);
        check("rst_disp", 32'(d_disp), 0);
        check("rst_hsync", 32'(d_hsync), 1);
        check("rst_vsync", 32'(d_vsync), 1);
        check("rst_ls", 32'(d_ls), 0);
        check("rst_fs", 32'(d_fs), 0);
        check("rst_r_hsync", 32'(r_hsync), 0);
        check("rst_r_vsync", 32'(r_vsync), 0);

        d_rst = 1'b1; m_rst = 1'b1; r_rst = 1'b1;
        repeat (2) cyc();
        check("idle_x", 32'(d_x), 799);
        check("idle_fs", 32'(d_fs), 0);

        // ---------------- first tick (divide-by-4 cadence) ----------------
        d_tick = 1'b1; cyc();
        check("first_x", 32'(d_x), 0);
        check("first_y", 32'(d_y), 0);
        check("first_fs", 32'(d_fs), 1);
        check("first_ls", 32'(d_ls), 1);
        check("first_disp", 32'(d_disp), 1);
        check("first_hsync", 32'(d_hsync), 1);
        d_tick = 1'b0; cyc();
        check("first_fs_clear", 32'(d_fs), 0);
        check("first_ls_clear", 32'(d_ls), 0);
        check("first_x_hold", 32'(d_x), 0);
        repeat (2) cyc();

        // ---------------- one full line, tick every 4th clk ----------------
        hs_low = 0; hs_bad = 0; disp_cnt = 0; disp_bad = 0;
        ls_cnt = 0; fs_cnt = 0; idle_pulse = 0; pos_bad = 0;
        for (int k = 1; k <= 800; k++) begin
            d_tick = 1'b1; cyc();
            xv = int'(d_x); yv = int'(d_y);
            if (xv != k % 800 || yv != k / 800) pos_bad++;
            if (d_hsync == 1'b0) hs_low++;
            if ((d_hsync == 1'b0) != (xv >= 656 && xv < 752)) hs_bad++;
            if (d_disp) disp_cnt++;
            if (d_disp != (xv < 640 && yv < 480)) disp_bad++;
            if (d_ls) ls_cnt++;
            if (d_fs) fs_cnt++;
            d_tick = 1'b0;
            for (int j = 0; j < 3; j++) begin
                cyc();
                if (d_ls || d_fs) idle_pulse++;
                if (int'(d_x) != xv || int'(d_y) != yv) pos_bad++;
            end
        end
        check("line_pos_bad", 32'(pos_bad), 0);
        check("line_hs_low", 32'(hs_low), 96);
        check("line_hs_bad", 32'(hs_bad), 0);
        check("line_disp_cnt", 32'(disp_cnt), 640);
        check("line_disp_bad", 32'(disp_bad), 0);
        check("line_ls_cnt", 32'(ls_cnt), 1);
        check("line_fs_cnt", 32'(fs_cnt), 0);
        check("line_idle_pulse", 32'(idle_pulse), 0);
        check("line_end_y", 32'(d_y), 1);

        // ---------------- reset mid-line at x=300 on a tick edge ----------------
        d_tick = 1'b1;
        repeat (300) cyc();
        check("mid_x", 32'(d_x), 300);
        d_rst = 1'b0; cyc();
        check("mid_rst_x", 32'(d_x), 799);
        check("mid_rst_y", 32'(d_y), 524);
        check("mid_rst_hsync", 32'(d_hsync), 1);
        check("mid_rst_disp", 32'(d_disp), 0);
        check("mid_rst_ls", 32'(d_ls), 0);
        d_rst = 1'b1; d_tick = 1'b0; cyc();
        check("mid_hold_x", 32'(d_x), 799);
        d_tick = 1'b1; cyc();
        check("mid_fs", 32'(d_fs), 1);
        check("mid_after_x", 32'(d_x), 0);
        check("mid_after_y", 32'(d_y), 0);
        d_tick = 1'b0;

        // ---------------- full frame, tick tied high ----------------
        mx = 6; my = 524;
        vs_low = 0; vs_bad = 0; ls_cnt = 0; ls_bad = 0; fs_cnt = 0; fs_bad = 0;
        pos_bad = 0; fs_first = -1; fs_last = -1;
        m_tick = 1'b1;
        for (int c = 1; c <= 3676; c++) begin
            cyc();
            els = (mx == 6);
            efs = els && (my == 524);
            if (mx == 6) begin
                mx = 0;
                my = (my == 524) ? 0 : my + 1;
            end else begin
                mx++;
            end
            if (int'(m_x) != mx || int'(m_y) != my) pos_bad++;
            if (m_vsync == 1'b0) vs_low++;
            if ((m_vsync == 1'b0) != (my >= 490 && my < 492)) vs_bad++;
            if (m_ls !== els) ls_bad++;
            if (m_fs !== efs) fs_bad++;
            if (m_ls) ls_cnt++;
            if (m_fs) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = c;
                else fs_last = c;
            end
        end
        check("frame_pos_bad", 32'(pos_bad), 0);
        check("frame_vs_low", 32'(vs_low), 14);
        check("frame_vs_bad", 32'(vs_bad), 0);
        check("frame_ls_bad", 32'(ls_bad), 0);
        check("frame_fs_bad", 32'(fs_bad), 0);
        check("frame_ls_cnt", 32'(ls_cnt), 526);
        check("frame_fs_cnt", 32'(fs_cnt), 2);
        check("frame_fs_period", 32'(fs_last - fs_first), 3675);

        // ---------------- reset at y=100 mid-frame ----------------
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            if (m_x == 3'd3 && m_y == 10'd100) found = 1'b1;
            else cyc();
        end
        check("seek_y100_found", 32'(found), 1);
        m_rst = 1'b0; cyc();
        check("y100_rst_x", 32'(m_x), 6);
        check("y100_rst_y", 32'(m_y), 524);
        check("y100_rst_vsync", 32'(m_vsync), 1);
        check("y100_rst_fs", 32'(m_fs), 0);
        m_rst = 1'b1; cyc();
        check("y100_next_fs", 32'(m_fs), 1);
        check("y100_next_y", 32'(m_y), 0);
        m_tick = 1'b0;

        // ---------------- reduced parameters, two frames, gapped ticks ----------------
        rx = 6; ry = 4;
        for (int i = 0; i < 105; i++) begin
            r_tick = (i % 3 != 2);
            cyc();
            els = 1'b0; efs = 1'b0;
            if (r_tick) begin
                if (rx == 6) begin
                    rx = 0;
                    els = 1'b1;
                    if (ry == 4) begin
                        ry = 0;
                        efs = 1'b1;
                    end else begin
                        ry++;
                    end
                end else begin
                    rx++;
                end
            end
            check("red_x", 32'(r_x), 32'(rx));
            check("red_y", 32'(r_y), 32'(ry));
            check("red_hsync", 32'(r_hsync), 32'(rx == 5));
            check("red_vsync", 32'(r_vsync), 32'(ry == 3));
            check("red_disp", 32'(r_disp), 32'(rx < 4 && ry < 2));
            check("red_ls", 32'(r_ls), 32'(els));
            check("red_fs", 32'(r_fs), 32'(efs));
        end
        r_tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vga_timing
`default_nettype wire

// File: doc/vga_timing.md
# vga_timing

Raster timing generator that consumes the pixel-rate `tick` strobe from `clock_divider` and produces horizontal/vertical sync, display-enable and pixel coordinates for the GPU video output. It runs entirely in the system `clk` domain; `tick` acts as a clock enable, so a pixel step occurs on every `clk` edge where `tick` is high. Downstream pixel fetch and the DAC/sync pins sit after it.

## Interface
- `H_VISIBLE`, default 640: active pixels per line
- `H_FRONT`, default 16: horizontal front porch, in pixels
- `H_SYNC`, default 96: hsync pulse width, in pixels
- `H_BACK`, default 48: horizontal back porch, in pixels
- `V_VISIBLE`, default 480: active lines per frame
- `V_FRONT`, default 10: vertical front porch, in lines
- `V_SYNC`, default 2: vsync width, in lines
- `V_BACK`, default 33: vertical back porch, in lines
- `H_SYNC_POL`, default 0: active level of `hsync`
- `V_SYNC_POL`, default 0: active level of `vsync`
- `X_WIDTH`, default 10: width of `x`; must hold H_TOTAL-1
- `Y_WIDTH`, default 10: width of `y`; must hold V_TOTAL-1
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-low
- `tick` in 1: pixel-rate enable from `clock_divider`
- `hsync` out 1: horizontal sync
- `vsync` out 1: vertical sync
- `display_on` out 1: high when the current (x,y) is within the visible area
- `x` out X_WIDTH: horizontal counter, 0..H_TOTAL-1
- `y` out Y_WIDTH: vertical counter, 0..V_TOTAL-1
- `line_start` out 1: one-`clk` pulse when `x` becomes 0
- `frame_start` out 1: one-`clk` pulse when (x,y) becomes (0,0)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL is defined the same way (525).
- On each edge with `tick`=1:
  - `x` increments.
  - At H_TOTAL-1, `x` wraps to 0 and `y` increments.
  - `y` at V_TOTAL-1 with `x` wrapping: `y` wraps to 0.
- With `tick`=0, all state holds. The pulse outputs clear to 0.
- `display_on` = (x < H_VISIBLE) && (y < V_VISIBLE).
- `hsync` = H_SYNC_POL while x is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC); otherwise it equals ~H_SYNC_POL.
- `vsync` follows the same rule on `y`, using the V_* parameters.
- Reset (`rst`=0 at an edge):
  - x = H_TOTAL-1, y = V_TOTAL-1.
  - display_on = 0, hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL, line_start = frame_start = 0.
  - The first tick after reset therefore enters (0,0) and fires `frame_start`.
- Reset wins over `tick` on the same edge. Reset mid-frame abandons the frame immediately, with no partial sync completion.
- Arithmetic is unsigned. Comparisons use full-width constants. No saturation is needed, because the wrap is explicit.

## Timing
- All outputs are registered and update on the same edge as the counters. No combinational path runs from `tick` to any output.
- Latency: for a tick at edge N, the new x/y, display_on, syncs and pulses are all valid after edge N. Latency is 1 clk and identical across all outputs (no skew).
- `line_start` / `frame_start` are high for exactly one `clk` cycle, even when `tick` is held high continuously (DIVISON=1).
- `frame_start` implies `line_start` on the same cycle.
- Between ticks, outputs are stable for the full tick period.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the 640x480@60 defaults (H_*/V_* values and polarities);
  - the derived H_TOTAL/V_TOTAL;
  - the X/Y widths.
- Sub-module `sync_axis_counter` is parameterized by VISIBLE/FRONT/SYNC/BACK/POL/WIDTH. It has inputs `clk`, `rst`, `en` and outputs `count`, `active`, `sync`, `wrap`.
  - It is instantiated twice: horizontal with `en`=`tick`; vertical with `en`=`tick` & h.`wrap`.
  - The top level adds the pulse logic and the `display_on` AND.

## Test plan
- **Reset**: hold rst=0 for 3 clk, then release. Expect x=799, y=524, display_on=0, hsync=vsync=1, and no pulses until the first tick.
- **First tick**: feed ticks from `clock_divider` with DIVISON=4. Expect x=0, y=0, frame_start=line_start=1 for one clk, and display_on=1.
- **Horizontal sync**: count ticks across one line. Expect hsync low exactly for x=656..751 (96 ticks), display_on high exactly for x=0..639, and line_start once per 800 ticks.
- **Vertical sync**: run a full frame with tick tied high. Expect vsync low exactly for y=490..491, frame_start once per 420000 clk, and one-clk pulses throughout.
- **Reset mid-line**: assert rst at x=300, y=100 on a tick edge. The next state must be x=799, y=524; the next tick yields frame_start.
- **Reduced parameters**: use H=4/1/1/1 and V=2/1/1/1 with POL=1. Verify the full x/y sequence over two frames, with hsync high at x=5 and vsync high at y=3.
